mdsa_result_collector: RTL and testbench
========================================

Name: mdsa_result_collector

Overview:
- Downstream stage of the MDSA odd-even sorter top.
- Captures the sorted N×N matrix streamed on the sorter's data_out/output_enable into a local frame buffer.
- Re-linearises it into snake order (odd rows reversed) and drains it on a valid/ready stream.
- While draining, checks that the drained stream is non-decreasing and reports frame/sort/overrun errors to the bench and system.

Parameters:
- DATA_WIDTH, 8, width of one matrix element.
- N, 4, matrix dimension; frame = N*N elements; N >= 2.
- SNAKE, 1, 1 = reverse column order on odd rows during drain; 0 = plain row-major.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- output_enable  in  1  sorter beat strobe; one element per cycle while high.
- data_out  in  DATA_WIDTH  sorter element, row-major (row 0 col 0 first).
- rdy  in  1  sorter done pulse; informational, latched into sorter_done_seen.
- m_data  out  DATA_WIDTH  drained element.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  high with the final (N*N-1th) drained element.
- collector_idle  out  1  high in IDLE; sorter may start a new frame.
- frame_done  out  1  one-cycle pulse after last element accepted.
- frame_err  out  1  sticky; short frame detected.
- sort_err  out  1  sticky; drained element < previous drained element.
- overrun  out  1  sticky; output_enable seen while not accepting.
- sorter_done_seen  out  1  sticky; rdy observed since reset/clear.
- clear_err  in  1  synchronous clear of all sticky flags.

Behaviour:
- Reset: state IDLE; all counters 0; m_data 0; m_valid 0; m_last 0; frame_done 0; all sticky flags 0; collector_idle 1.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - output_enable=1 writes data_out at row 0, col 0 and moves to CAPTURE with wr_count=1.
  - N*N=1 is impossible since N>=2.
- CAPTURE:
  - Each cycle with output_enable=1 writes the buffer at (wr_row, wr_col), then advances col; wrap col N-1 -> 0 and increments row.
  - After beat N*N-1 is written, go to DRAIN next cycle.
  - output_enable=0 before N*N beats: set frame_err, discard partial frame, return to IDLE.
- DRAIN:
  - Read index rd_row/rd_col. Physical column = N-1-rd_col when SNAKE=1 and rd_row odd, else rd_col.
  - m_valid rises the first cycle in DRAIN; m_data/m_valid are registered.
  - On m_valid & m_ready, advance to the next element.
  - While m_valid & !m_ready, m_data, m_valid and m_last hold stable.
  - m_last = 1 exactly on element N*N-1.
  - On the accept of the m_last beat: m_valid drops next cycle, frame_done pulses that cycle, state returns to IDLE.
- Sort check:
  - On each accepted beat except the first of a frame, set sort_err if m_data < last accepted value (unsigned compare).
  - The first beat only loads the reference value.
- Overrun: output_enable=1 in DRAIN sets overrun; the element is dropped and the buffer is not written.
- Latency: last capture beat to first m_valid = 2 cycles (1 state transition + 1 output register).
- Throughput: 1 element/cycle with m_ready tied high.
- Simultaneous events:
  - clear_err together with a set condition: the set wins.
  - rdy and output_enable together: both handled independently.
- Reset mid-frame: any state goes to IDLE immediately (async); buffer contents are don't-care.

Decomposition:
- Package mdsa_pkg holds:
  - typedef elem_t (logic [DATA_WIDTH-1:0]);
  - localparams FRAME_LEN = N*N, IDX_W = $clog2(FRAME_LEN), RC_W = $clog2(N);
  - enum collector_state_e {IDLE, CAPTURE, DRAIN}.
- One sub-module, mdsa_frame_buffer: N*N × DATA_WIDTH register array, one write port (row, col) and one combinational read port. The snake index mapping stays in the parent.

Test Plan:
- Basic: N=4, SNAKE=1, sorter rows [0 1 2 3] [7 6 5 4] [8 9 10 11] [15 14 13 12], m_ready=1 -> m_data 0..15 on consecutive cycles; m_last on 15; frame_done one cycle later; all error flags 0.
- Backpressure: same frame, m_ready toggling 1,0,0,1… -> every element delivered exactly once, m_data stable while stalled, order 0..15, no sort_err.
- Short frame: output_enable drops after 10 beats -> frame_err=1, m_valid never asserts, collector_idle=1 the next cycle; a following full frame drains correctly.
- Unsorted input: row 0 = [0 1 3 2] -> sort_err set on the beat carrying 2; drain still completes 16 beats.
- Overrun: assert output_enable for 1 cycle during DRAIN with m_ready=0 -> overrun=1, drained data unchanged; clear_err pulse -> all sticky flags 0.
- Reset mid-DRAIN after 5 accepts: assert rst -> m_valid=0, m_data=0, collector_idle=1 asynchronously; the next frame drains from element 0.

Source files
------------

// File: rtl/mdsa_pkg.sv
// Shared types and default sizing for the MDSA result collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default element width and matrix size, element type, frame
// length and index widths for the default size, collector state encoding.
package mdsa_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int N_DEF          = 4;

   localparam int FRAME_LEN = N_DEF * N_DEF;
   localparam int IDX_W     = $clog2(FRAME_LEN);
   localparam int RC_W      = $clog2(N_DEF);

   typedef logic [DATA_WIDTH_DEF-1:0] elem_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } collector_state_e;

endpackage

// File: rtl/mdsa_result_collector_if.sv
// Bundles the sorter-facing, drain-stream and status signals of the collector.
// Latency: n/a (wires only).
// Backpressure: m_valid/m_ready on the drain stream; sorter side has none.
// Modports: slave = collector view, master = sorter/downstream/system view.
interface mdsa_result_collector_if
   import mdsa_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  output_enable;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rdy;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;
   logic                  collector_idle;
   logic                  frame_done;
   logic                  frame_err;
   logic                  sort_err;
   logic                  overrun;
   logic                  sorter_done_seen;
   logic                  clear_err;

   modport slave (
      input  output_enable, data_out, rdy, m_ready, clear_err,
      output m_data, m_valid, m_last, collector_idle, frame_done,
             frame_err, sort_err, overrun, sorter_done_seen
   );

   modport master (
      output output_enable, data_out, rdy, m_ready, clear_err,
      input  m_data, m_valid, m_last, collector_idle, frame_done,
             frame_err, sort_err, overrun, sorter_done_seen
   );
endinterface

// File: rtl/mdsa_frame_buffer.sv
// N x N element store: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after we_i; read is combinational.
// Backpressure: none; the parent sequences all accesses.
// Ports: clk; we_i/wr_row_i/wr_col_i/wr_dat_i write; rd_row_i/rd_col_i -> rd_dat_o read.
module mdsa_frame_buffer
   import mdsa_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int N          = N_DEF,
   localparam int RCW       = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [RCW-1:0]        wr_row_i,
   input  logic [RCW-1:0]        wr_col_i,
   input  logic [DATA_WIDTH-1:0] wr_dat_i,
   input  logic [RCW-1:0]        rd_row_i,
   input  logic [RCW-1:0]        rd_col_i,
   output logic [DATA_WIDTH-1:0] rd_dat_o
);

   // Contents are don't-care after reset, so the array carries no reset.
   logic [DATA_WIDTH-1:0] mem_q [N][N];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_row_i][wr_col_i] <= wr_dat_i;
      end
   end

   assign rd_dat_o = mem_q[rd_row_i][rd_col_i];

endmodule

// File: rtl/mdsa_result_collector.sv
// Captures a sorted N x N frame from the sorter, drains it in snake order, checks ordering.
// Latency: 2 cycles from the last capture beat to the first m_valid; 1 element/cycle when m_ready is high.
// Backpressure: m_data/m_valid/m_last hold while m_valid & !m_ready; sorter beats arriving during drain are dropped (overrun).
// Ports: clk, rst (async, active high); bus (slave modport): output_enable/data_out/rdy in from the sorter,
//        m_data/m_valid/m_ready/m_last drain stream, collector_idle/frame_done status, sticky error flags, clear_err.
module mdsa_result_collector
   import mdsa_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int N          = N_DEF,
   parameter bit SNAKE      = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   mdsa_result_collector_if.slave bus
);

   localparam int             RCW     = $clog2(N);
   localparam logic [RCW-1:0] LAST_RC = RCW'(N - 1);
   localparam logic [RCW-1:0] ONE_RC  = RCW'(1);

   collector_state_e      state_q, state_d;
   logic [RCW-1:0]        wr_row_q, wr_row_d, wr_col_q, wr_col_d;
   logic [RCW-1:0]        rd_row_q, rd_row_d, rd_col_q, rd_col_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d, ref_q, ref_d;
   logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic                  frame_done_q, frame_done_d, first_q, first_d;
   logic                  frame_err_q, frame_err_d, sort_err_q, sort_err_d;
   logic                  overrun_q, overrun_d, done_seen_q, done_seen_d;

   logic                  buf_we;
   logic [RCW-1:0]        buf_row, buf_col, phys_col;
   logic [DATA_WIDTH-1:0] rd_dat;
   logic                  accept;
   logic                  frame_set, sort_set, overrun_set;

   assign accept = m_valid_q & bus.m_ready;

   // Odd rows are stored as the sorter produced them (descending), so the
   // drain walks them backwards to yield a single ascending stream.
   assign phys_col = (SNAKE && rd_row_q[0]) ? (LAST_RC - rd_col_q) : rd_col_q;

   mdsa_frame_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N)
   ) u_frame_buffer (
      .clk      (clk),
      .we_i     (buf_we),
      .wr_row_i (buf_row),
      .wr_col_i (buf_col),
      .wr_dat_i (bus.data_out),
      .rd_row_i (rd_row_q),
      .rd_col_i (phys_col),
      .rd_dat_o (rd_dat)
   );

   always_comb begin
      state_d      = state_q;
      wr_row_d     = wr_row_q;
      wr_col_d     = wr_col_q;
      rd_row_d     = rd_row_q;
      rd_col_d     = rd_col_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      ref_d        = ref_q;
      first_d      = first_q;
      frame_done_d = 1'b0;
      buf_we       = 1'b0;
      buf_row      = wr_row_q;
      buf_col      = wr_col_q;
      frame_set    = 1'b0;
      sort_set     = 1'b0;
      overrun_set  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.output_enable) begin
               buf_we   = 1'b1;
               buf_row  = '0;
               buf_col  = '0;
               wr_row_d = '0;
               wr_col_d = ONE_RC;
               state_d  = CAPTURE;
            end
         end

         CAPTURE: begin
            if (bus.output_enable) begin
               buf_we = 1'b1;
               if (wr_col_q == LAST_RC) begin
                  wr_col_d = '0;
                  wr_row_d = wr_row_q + ONE_RC;
                  if (wr_row_q == LAST_RC) begin
                     state_d  = DRAIN;
                     rd_row_d = '0;
                     rd_col_d = '0;
                     first_d  = 1'b1;
                  end
               end else begin
                  wr_col_d = wr_col_q + ONE_RC;
               end
            end else begin
               // Gap in the beat stream: the partial frame is abandoned.
               frame_set = 1'b1;
               state_d   = IDLE;
            end
         end

         DRAIN: begin
            overrun_set = bus.output_enable;

            if (accept) begin
               first_d = 1'b0;
               ref_d   = m_data_q;
               if (!first_q && (m_data_q < ref_q)) begin
                  sort_set = 1'b1;
               end
               if (m_last_q) begin
                  m_valid_d    = 1'b0;
                  m_last_d     = 1'b0;
                  frame_done_d = 1'b1;
                  state_d      = IDLE;
               end
            end

            // Refill the output register when it is empty or its beat is
            // leaving, unless the beat leaving is the last of the frame.
            if (!m_valid_q || (accept && !m_last_q)) begin
               m_data_d  = rd_dat;
               m_valid_d = 1'b1;
               m_last_d  = (rd_row_q == LAST_RC) && (rd_col_q == LAST_RC);
               if (rd_col_q == LAST_RC) begin
                  rd_col_d = '0;
                  rd_row_d = rd_row_q + ONE_RC;
               end else begin
                  rd_col_d = rd_col_q + ONE_RC;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      // A set condition in the same cycle as clear_err wins.
      frame_err_d = frame_set   | (frame_err_q & ~bus.clear_err);
      sort_err_d  = sort_set    | (sort_err_q  & ~bus.clear_err);
      overrun_d   = overrun_set | (overrun_q   & ~bus.clear_err);
      done_seen_d = bus.rdy     | (done_seen_q & ~bus.clear_err);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_row_q     <= '0;
         wr_col_q     <= '0;
         rd_row_q     <= '0;
         rd_col_q     <= '0;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         ref_q        <= '0;
         first_q      <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         sort_err_q   <= 1'b0;
         overrun_q    <= 1'b0;
         done_seen_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_row_q     <= wr_row_d;
         wr_col_q     <= wr_col_d;
         rd_row_q     <= rd_row_d;
         rd_col_q     <= rd_col_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         ref_q        <= ref_d;
         first_q      <= first_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         sort_err_q   <= sort_err_d;
         overrun_q    <= overrun_d;
         done_seen_q  <= done_seen_d;
      end
   end

   assign bus.m_data           = m_data_q;
   assign bus.m_valid          = m_valid_q;
   assign bus.m_last           = m_last_q;
   assign bus.collector_idle   = (state_q == IDLE);
   assign bus.frame_done       = frame_done_q;
   assign bus.frame_err        = frame_err_q;
   assign bus.sort_err         = sort_err_q;
   assign bus.overrun          = overrun_q;
   assign bus.sorter_done_seen = done_seen_q;

endmodule

// File: tb/tb_mdsa_result_collector.sv
// Bench for mdsa_result_collector: directed plan steps plus random frames and random backpressure.
// Expected drain order, ordering errors and sticky flags come from a frame-level model.
module tb_mdsa_result_collector;
   import mdsa_pkg::*;

   localparam int N  = N_DEF;
   localparam int FL = FRAME_LEN;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   mdsa_result_collector_if #(.DATA_WIDTH(DATA_WIDTH_DEF)) bus ();

   mdsa_result_collector #(
      .DATA_WIDTH (DATA_WIDTH_DEF),
      .N          (N),
      .SNAKE      (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Frame as presented by the sorter (row-major), and expected drain stream.
   elem_t frame [FL];
   elem_t exp_q [$];
   elem_t got_q [$];
   bit    last_q [$];
   bit    exp_ferr, exp_serr, exp_ovr, exp_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Snake read-out: even rows left to right, odd rows right to left.
   function automatic void model_drain();
      exp_q.delete();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            exp_q.push_back(frame[r*N + ((r % 2 == 1) ? (N - 1 - c) : c)]);
   endfunction

   function automatic int model_first_drop();
      for (int i = 1; i < FL; i++)
         if (exp_q[i] < exp_q[i-1]) return i;
      return -1;
   endfunction

   function automatic void basic_frame();
      int rows [FL] = '{0,1,2,3, 7,6,5,4, 8,9,10,11, 15,14,13,12};
      for (int i = 0; i < FL; i++) frame[i] = elem_t'(rows[i]);
   endfunction

   task automatic check_flags(input string tag);
      check({tag, "_frame_err"}, bus.frame_err,        exp_ferr);
      check({tag, "_sort_err"},  bus.sort_err,         exp_serr);
      check({tag, "_overrun"},   bus.overrun,          exp_ovr);
      check({tag, "_done_seen"}, bus.sorter_done_seen, exp_seen);
   endtask

   task automatic clear_flags();
      @(negedge clk);
      bus.clear_err = 1'b1;
      @(negedge clk);
      bus.clear_err = 1'b0;
      exp_ferr = 0; exp_serr = 0; exp_ovr = 0; exp_seen = 0;
      check_flags("clear");
   endtask

   // Presents the first 'beats' elements of frame[], one per cycle.
   task automatic send(input int beats, input bit rdy_on_last);
      for (int i = 0; i < beats; i++) begin
         @(negedge clk);
         bus.output_enable = 1'b1;
         bus.data_out      = frame[i];
         bus.rdy           = rdy_on_last && (i == beats - 1);
      end
      @(negedge clk);
      bus.output_enable = 1'b0;
      bus.rdy           = 1'b0;
      if (rdy_on_last) exp_seen = 1;
   endtask

   // rmode 0: ready high; 1: ready pattern 1,0,0,1; 2: random ready.
   task automatic drain(input string tag, input int rmode, output int first_cyc, output int last_cyc);
      bit    done, stalled, chk_serr;
      elem_t held;
      bit    held_last;
      int    serr_at, exp_drop;
      done = 0; stalled = 0; held = '0; held_last = 0;
      first_cyc = -1; last_cyc = -1; serr_at = -1;
      chk_serr = !exp_serr;
      got_q.delete(); last_q.delete();
      model_drain();
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         case (rmode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: bus.m_ready = ($urandom_range(0, 2) != 0);
         endcase
         if (bus.sort_err && serr_at < 0) serr_at = got_q.size();
         if (bus.m_valid && first_cyc < 0) first_cyc = cyc;
         if (stalled) begin
            check({tag, "_stall_valid"}, bus.m_valid, 1);
            check({tag, "_stall_data"},  bus.m_data,  held);
            check({tag, "_stall_last"},  bus.m_last,  held_last);
         end
         if (bus.m_valid && bus.m_ready) begin
            got_q.push_back(bus.m_data);
            last_q.push_back(bus.m_last);
            stalled = 0;
            if (bus.m_last) begin
               done = 1;
               last_cyc = cyc;
            end
         end else begin
            stalled   = bus.m_valid;
            held      = bus.m_data;
            held_last = bus.m_last;
         end
      end
      check({tag, "_drain_completed"}, done, 1);
      @(negedge clk);
      if (bus.sort_err && serr_at < 0) serr_at = got_q.size();
      check({tag, "_frame_done"},  bus.frame_done,     1);
      check({tag, "_valid_drops"}, bus.m_valid,        0);
      check({tag, "_idle_after"},  bus.collector_idle, 1);
      check({tag, "_beats"},       got_q.size(),       FL);
      for (int i = 0; i < FL && i < got_q.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), got_q[i],  exp_q[i]);
         check($sformatf("%s_last%0d", tag, i), last_q[i], (i == FL - 1));
      end
      exp_drop = model_first_drop();
      if (chk_serr) check({tag, "_sort_err_beat"}, serr_at, (exp_drop < 0) ? -1 : exp_drop + 1);
      if (exp_drop >= 0) exp_serr = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int    fc, lc, anyv;
      elem_t s [$];

      rst = 1'b1;
      bus.output_enable = 1'b0; bus.data_out = '0; bus.rdy = 1'b0;
      bus.m_ready = 1'b0; bus.clear_err = 1'b0;
      exp_ferr = 0; exp_serr = 0; exp_ovr = 0; exp_seen = 0;
      #12;
      check("rst_m_valid",    bus.m_valid,        0);
      check("rst_m_data",     bus.m_data,         0);
      check("rst_m_last",     bus.m_last,         0);
      check("rst_frame_done", bus.frame_done,     0);
      check("rst_idle",       bus.collector_idle, 1);
      check_flags("rst");
      @(negedge clk);
      rst = 1'b0;

      // Basic frame, ready held high, rdy pulsed together with the last beat.
      basic_frame();
      bus.m_ready = 1'b1;
      send(FL, 1'b1);
      check("basic_not_yet_valid", bus.m_valid, 0);
      drain("basic", 0, fc, lc);
      check("basic_latency", fc, 0);
      check("basic_throughput", lc, FL - 1);
      check_flags("basic");

      // Backpressure pattern.
      send(FL, 1'b0);
      drain("bp", 1, fc, lc);
      check_flags("bp");

      // Short frame: 10 beats then a gap.
      send(10, 1'b0);
      @(negedge clk);
      exp_ferr = 1;
      check("short_idle", bus.collector_idle, 1);
      check_flags("short");
      anyv = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.m_valid) anyv = 1;
      end
      check("short_no_valid", anyv, 0);
      send(FL, 1'b0);
      drain("after_short", 0, fc, lc);
      check_flags("after_short");

      // Unsorted row 0: [0 1 3 2].
      clear_flags();
      basic_frame();
      frame[2] = 8'd3; frame[3] = 8'd2;
      send(FL, 1'b0);
      drain("unsorted", 0, fc, lc);
      check_flags("unsorted");

      // Overrun during drain with the output stalled, then clear.
      clear_flags();
      basic_frame();
      bus.m_ready = 1'b0;
      send(FL, 1'b0);
      @(negedge clk);
      bus.output_enable = 1'b1;
      bus.data_out      = 8'hEE;
      @(negedge clk);
      bus.output_enable = 1'b0;
      exp_ovr = 1;
      check("ovr_flag",        bus.overrun, 1);
      check("ovr_head_intact", bus.m_data,  0);
      drain("ovr", 0, fc, lc);
      check_flags("ovr");
      clear_flags();

      // clear_err coinciding with overrun and rdy: the sets win.
      bus.m_ready = 1'b0;
      send(FL, 1'b0);
      @(negedge clk);
      bus.output_enable = 1'b1; bus.clear_err = 1'b1; bus.rdy = 1'b1;
      @(negedge clk);
      bus.output_enable = 1'b0; bus.clear_err = 1'b0; bus.rdy = 1'b0;
      exp_ovr = 1; exp_seen = 1;
      check_flags("setwins");
      drain("setwins", 0, fc, lc);

      // Asynchronous reset after five accepted beats.
      bus.m_ready = 1'b1;
      send(FL, 1'b0);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("amid_m_valid", bus.m_valid,        0);
      check("amid_m_data",  bus.m_data,         0);
      check("amid_idle",    bus.collector_idle, 1);
      exp_ferr = 0; exp_serr = 0; exp_ovr = 0; exp_seen = 0;
      check_flags("amid");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < FL; i++) frame[i] = elem_t'(8'd100 + 8'(i));
      send(FL, 1'b0);
      drain("post_rst", 0, fc, lc);

      // Random frames: even ones sorted into sorter order, odd ones raw.
      for (int k = 0; k < 6; k++) begin
         clear_flags();
         if (k % 2 == 0) begin
            s.delete();
            for (int i = 0; i < FL; i++) s.push_back(elem_t'($urandom_range(0, 255)));
            s.sort();
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++)
                  frame[r*N + ((r % 2 == 1) ? (N - 1 - c) : c)] = s[r*N + c];
         end else begin
            for (int i = 0; i < FL; i++) frame[i] = elem_t'($urandom_range(0, 255));
         end
         send(FL, 1'b0);
         drain($sformatf("rand%0d", k), 2, fc, lc);
         check_flags($sformatf("rand%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
